sram_async_ctrl: RTL and testbench
==================================

# sram_async_ctrl

Parametrised controller for the board's external asynchronous SRAM. It replaces the purely combinational SRAM pass-through with a registered, multi-cycle access engine. It sits between the core's memory port (valid/ready request, single-cycle response pulse) and the SRAM pins. It provides configurable read/write wait states, byte-masked writes and a guaranteed bus turnaround after every write. All SRAM strobes are registered.

## Interface
- ADDR_W, 20, SRAM word-address width
- DATA_W, 32, data width; must be a multiple of 8
- RD_WAIT, 1, cycles ram_oe_n is held low per read; ≥1
- WR_WAIT, 1, cycles ram_we_n is held low per write; ≥1
- TURN, 1, cycles after a write with all strobes high and data still driven (hold/turnaround); ≥1

Ports:
- clock  in  1  sole clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- io_req_valid  in  1  request valid
- io_req_ready  out  1  controller accepts request this cycle
- io_req_we  in  1  1 = write, 0 = read
- io_req_addr  in  ADDR_W  word address
- io_req_wdata  in  DATA_W  write data
- io_req_wmask  in  DATA_W/8  byte enables, active-high
- io_resp_valid  out  1  one-cycle completion pulse (reads and writes)
- io_resp_rdata  out  DATA_W  read data; holds last read value
- ram_data  inout  DATA_W  SRAM data bus
- ram_addr  out  ADDR_W  SRAM address
- ram_be_n, ram_ce_n, ram_oe_n, ram_we_n  out  DATA_W/8,1,1,1  active-low SRAM controls

## Operation
- States: IDLE, RD, WR, TURN. Handshake completes on io_req_valid & io_req_ready; request fields are captured into registers. Request inputs are ignored while ready is low.
- IDLE: io_req_ready=1, all strobes high, bus released. Read accept → RD. Write accept → WR.
- RD: ram_ce_n=0, ram_oe_n=0, ram_be_n=0, ram_addr=captured addr, bus released. A down-counter is loaded with RD_WAIT. On the edge ending the last RD cycle, ram_data is sampled into io_resp_rdata → IDLE with io_resp_valid=1.
- WR: ram_ce_n=0, ram_we_n=0, ram_be_n=~wmask, bus driven with wdata, for WR_WAIT cycles → TURN.
- TURN: strobes high, ram_addr and bus drive held, for TURN cycles. io_resp_valid=1 in the first TURN cycle. After TURN → IDLE and the bus is released.
- A wmask of 0 still executes a full write cycle (be_n all 1) and responds.
- io_resp_rdata changes only on read completion. Write responses leave it unchanged.
- Invariant: the bus is never driven in any cycle where ram_oe_n=0.
- Reset (async, any state): state=IDLE, ram_ce_n/oe_n/we_n=1, ram_be_n=all 1, ram_addr=0, bus released, io_resp_valid=0, io_resp_rdata=0. An in-flight access is abandoned with no response. io_req_ready=1 after reset.

## Timing
- Accept on edge 0.
- Read: strobes low in cycles 1..RD_WAIT. io_resp_valid and data in cycle RD_WAIT+1. Ready returns in cycle RD_WAIT+1, so the back-to-back read period is RD_WAIT+1.
- Write: we_n low in cycles 1..WR_WAIT. Response in cycle WR_WAIT+1. Ready returns in cycle WR_WAIT+TURN+1.
- All ram_* outputs come from flops. io_req_ready is decoded from state only, with no combinational path from io_req_valid.

## Configuration
- SRAM_ASYNC_CTRL_REQ_BUF_EN defined: a one-entry request buffer is added.
  - io_req_ready = buffer empty, in every state.
  - In IDLE with the buffer empty, a request bypasses the buffer; latency is unchanged.
  - Otherwise the request is buffered and started on the cycle the FSM enters IDLE (no idle gap). TURN is still honoured.
  - Order is strictly preserved. Reset empties the buffer.
- Undefined: no buffer; io_req_ready=1 only in IDLE.

## Structure
- Package sram_async_ctrl_pkg holds:
  - the state enum (S_IDLE, S_RD, S_WR, S_TURN);
  - a packed request struct (we, addr, wdata, wmask) parametrised by widths via typedef in the module;
  - a localparam computing the wait-counter width from max(RD_WAIT, WR_WAIT, TURN).
- Sub-module sram_req_buf: one-entry valid/ready buffer, instantiated only under SRAM_ASYNC_CTRL_REQ_BUF_EN.

## Test plan
- Defaults, write 0xDEADBEEF mask 0xF to addr 0x00010:
  - cycle 1: ram_we_n=0, ram_be_n=0000, bus=0xDEADBEEF;
  - cycle 2: io_resp_valid=1, bus still driven, we_n=1;
  - cycle 3: ready=1.
- Read 0x00010 after that write: ram_oe_n=0 in cycle 1, io_resp_valid=1 and io_resp_rdata=0xDEADBEEF in cycle 2.
- Write 0x0000AA00 mask 0x2 to 0x00010, then read: ram_be_n=1101 during the write; the read returns 0xDEADAAEF.
- RD_WAIT=3, WR_WAIT=2, TURN=2, write immediately followed by read:
  - we_n low for exactly 2 cycles;
  - oe_n is not low until 2 cycles after we_n rises;
  - the bus is never driven while oe_n=0.
- reset_n asserted in the middle of a WR cycle: all strobes high and bus released within the same cycle (async), no io_resp_valid, io_req_ready=1 after release.
- REQ_BUF_EN, four back-to-back reads to 0,1,2,3: ready never drops before the buffer fills, there are four resp pulses in order, and the read period is RD_WAIT+1 cycles.

Source files
------------

// File: rtl/sram_async_ctrl_pkg.sv
// sram_async_ctrl_pkg
// Shared types and helpers for the external asynchronous SRAM controller.
//   state_t      : access FSM states
//   sram_cnt_w() : width of the wait-state down-counter
//   CNT_W_DEFAULT: counter width for the default wait-state configuration
// The request struct depends on module widths, so it is typedef'd inside
// sram_async_ctrl rather than here.
package sram_async_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_TURN = 2'd3
    } state_t;

    // The counter is loaded with (wait - 1) and counts down to zero, so it
    // only needs to hold max(RD_WAIT, WR_WAIT, TURN) - 1.
    function automatic int sram_cnt_w(input int rd, input int wr, input int turn);
        int m;
        m = rd;
        if (wr > m)   m = wr;
        if (turn > m) m = turn;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    localparam int CNT_W_DEFAULT = sram_cnt_w(1, 1, 1);

endpackage

// File: rtl/sram_req_buf.sv
// sram_req_buf
// One-entry valid/ready request buffer with bypass.
//   clock, reset_n         : clock, async active-low reset (empties buffer)
//   in_valid/in_ready      : upstream handshake; in_ready = buffer empty
//   in_data                : upstream payload
//   out_valid/out_ready    : downstream handshake
//   out_data               : buffered entry if full, else in_data (bypass)
// When empty and downstream is ready, a request passes straight through
// with no added latency. in_ready is a flop output only.
module sram_req_buf #(
    parameter int W = 1
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         full;
    logic [W-1:0] q;

    assign in_ready  = !full;
    assign out_valid = full || in_valid;
    assign out_data  = full ? q : in_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            full <= 1'b0;
            q    <= '0;
        end else if (full) begin
            if (out_ready) full <= 1'b0;
        end else if (in_valid && !out_ready) begin
            full <= 1'b1;
            q    <= in_data;
        end
    end

endmodule

// File: rtl/sram_async_ctrl.sv
// sram_async_ctrl
// Registered multi-cycle access engine for the external asynchronous SRAM.
//   clock, reset_n           : clock, async active-low reset
//   io_req_*                 : core request (valid/ready, we, addr, wdata, wmask)
//   io_resp_valid            : one-cycle completion pulse for reads and writes
//   io_resp_rdata            : last read data (held until next read completes)
//   ram_data                 : bidirectional SRAM data bus
//   ram_addr, ram_be_n,
//   ram_ce_n, ram_oe_n,
//   ram_we_n                 : SRAM address and active-low strobes (all flops)
// Optional feature: define SRAM_ASYNC_CTRL_REQ_BUF_EN to add a one-entry
// request buffer so a new request can be taken while an access is running.
module sram_async_ctrl
    import sram_async_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 32,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1,
    parameter int TURN    = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  io_req_valid,
    output logic                  io_req_ready,
    input  logic                  io_req_we,
    input  logic [ADDR_W-1:0]     io_req_addr,
    input  logic [DATA_W-1:0]     io_req_wdata,
    input  logic [DATA_W/8-1:0]   io_req_wmask,
    output logic                  io_resp_valid,
    output logic [DATA_W-1:0]     io_resp_rdata,
    inout  wire  [DATA_W-1:0]     ram_data,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W/8-1:0]   ram_be_n,
    output logic                  ram_ce_n,
    output logic                  ram_oe_n,
    output logic                  ram_we_n
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = sram_cnt_w(RD_WAIT, WR_WAIT, TURN);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   wmask;
    } req_t;

    localparam int REQ_W = $bits(req_t);

    req_t             in_req, fsm_req;
    logic             fsm_valid, fsm_ready, accept;
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    // Captured request fields and bus driver state
    logic [BE_W-1:0]   wmask_q;
    logic [DATA_W-1:0] dout_q;
    logic              drive_q;

    // Next-cycle strobe values, registered below
    logic              ce_d, oe_d, we_d, drive_d, resp_d;
    logic [BE_W-1:0]   be_d;

    assign in_req    = '{io_req_we, io_req_addr, io_req_wdata, io_req_wmask};
    assign fsm_ready = (state == S_IDLE);
    assign accept    = fsm_valid && fsm_ready;

`ifdef SRAM_ASYNC_CTRL_REQ_BUF_EN
    logic [REQ_W-1:0] buf_out;

    sram_req_buf #(.W(REQ_W)) u_req_buf (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (io_req_valid),
        .in_ready  (io_req_ready),
        .in_data   (in_req),
        .out_valid (fsm_valid),
        .out_ready (fsm_ready),
        .out_data  (buf_out)
    );

    assign fsm_req = req_t'(buf_out);
`else
    assign fsm_valid    = io_req_valid;
    assign fsm_req      = in_req;
    assign io_req_ready = fsm_ready;
`endif

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next state: counter holds remaining cycles minus one in the current phase
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (fsm_req.we) begin
                        state_nx = S_WR;
                        cnt_nx   = CNT_W'(WR_WAIT - 1);
                    end else begin
                        state_nx = S_RD;
                        cnt_nx   = CNT_W'(RD_WAIT - 1);
                    end
                end
            end
            S_RD: begin
                if (cnt == '0) state_nx = S_IDLE;
                else           cnt_nx   = cnt - CNT_W'(1);
            end
            S_WR: begin
                if (cnt == '0) begin
                    state_nx = S_TURN;
                    cnt_nx   = CNT_W'(TURN - 1);
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            S_TURN: begin
                if (cnt == '0) state_nx = S_IDLE;
                else           cnt_nx   = cnt - CNT_W'(1);
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs: decoded from the state being entered so that every SRAM pin
    // comes straight from a flop. Read (oe) and drive are never both set.
    always_comb begin
        ce_d    = 1'b1;
        oe_d    = 1'b1;
        we_d    = 1'b1;
        be_d    = '1;
        drive_d = 1'b0;
        case (state_nx)
            S_RD: begin
                ce_d = 1'b0;
                oe_d = 1'b0;
                be_d = '0;
            end
            S_WR: begin
                ce_d    = 1'b0;
                we_d    = 1'b0;
                be_d    = accept ? ~fsm_req.wmask : ~wmask_q;
                drive_d = 1'b1;
            end
            S_TURN:  drive_d = 1'b1;
            default: ;
        endcase
        resp_d = ((state == S_RD) || (state == S_WR)) && (cnt == '0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ram_ce_n      <= 1'b1;
            ram_oe_n      <= 1'b1;
            ram_we_n      <= 1'b1;
            ram_be_n      <= '1;
            ram_addr      <= '0;
            drive_q       <= 1'b0;
            dout_q        <= '0;
            wmask_q       <= '0;
            io_resp_valid <= 1'b0;
            io_resp_rdata <= '0;
        end else begin
            ram_ce_n      <= ce_d;
            ram_oe_n      <= oe_d;
            ram_we_n      <= we_d;
            ram_be_n      <= be_d;
            drive_q       <= drive_d;
            io_resp_valid <= resp_d;
            if (accept) begin
                ram_addr <= fsm_req.addr;
                dout_q   <= fsm_req.wdata;
                wmask_q  <= fsm_req.wmask;
            end
            // Sample on the edge that ends the last oe_n-low cycle
            if ((state == S_RD) && (cnt == '0)) io_resp_rdata <= ram_data;
        end
    end

    assign ram_data = drive_q ? dout_q : 'z;

endmodule

// File: tb/tb_sram_async_ctrl.sv
module tb_sram_async_ctrl;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // ---------------- instance A: default wait states ----------------
    logic        a_valid, a_ready, a_we, a_resp;
    logic [19:0] a_addr, a_raddr;
    logic [31:0] a_wdata, a_rdata;
    logic [3:0]  a_wmask, a_be_n;
    logic        a_ce_n, a_oe_n, a_we_n;
    wire  [31:0] a_bus;
    logic [31:0] mem_a [32];

    sram_async_ctrl u_dut_a (
        .clock(clock), .reset_n(reset_n),
        .io_req_valid(a_valid), .io_req_ready(a_ready), .io_req_we(a_we),
        .io_req_addr(a_addr), .io_req_wdata(a_wdata), .io_req_wmask(a_wmask),
        .io_resp_valid(a_resp), .io_resp_rdata(a_rdata),
        .ram_data(a_bus), .ram_addr(a_raddr), .ram_be_n(a_be_n),
        .ram_ce_n(a_ce_n), .ram_oe_n(a_oe_n), .ram_we_n(a_we_n)
    );

    assign a_bus = (!a_ce_n && !a_oe_n) ? mem_a[a_raddr[4:0]] : 'z;
    always @(posedge clock)
        if (!a_ce_n && !a_we_n)
            for (int i = 0; i < 4; i++)
                if (!a_be_n[i]) mem_a[a_raddr[4:0]][i*8 +: 8] = a_bus[i*8 +: 8];

    // ---------------- instance B: RD_WAIT=3 WR_WAIT=2 TURN=2 ----------------
    logic        b_valid, b_ready, b_we, b_resp;
    logic [19:0] b_addr, b_raddr;
    logic [31:0] b_wdata, b_rdata;
    logic [3:0]  b_wmask, b_be_n;
    logic        b_ce_n, b_oe_n, b_we_n;
    wire  [31:0] b_bus;
    logic [31:0] mem_b [32];

    sram_async_ctrl #(.RD_WAIT(3), .WR_WAIT(2), .TURN(2)) u_dut_b (
        .clock(clock), .reset_n(reset_n),
        .io_req_valid(b_valid), .io_req_ready(b_ready), .io_req_we(b_we),
        .io_req_addr(b_addr), .io_req_wdata(b_wdata), .io_req_wmask(b_wmask),
        .io_resp_valid(b_resp), .io_resp_rdata(b_rdata),
        .ram_data(b_bus), .ram_addr(b_raddr), .ram_be_n(b_be_n),
        .ram_ce_n(b_ce_n), .ram_oe_n(b_oe_n), .ram_we_n(b_we_n)
    );

    assign b_bus = (!b_ce_n && !b_oe_n) ? mem_b[b_raddr[4:0]] : 'z;
    always @(posedge clock)
        if (!b_ce_n && !b_we_n)
            for (int i = 0; i < 4; i++)
                if (!b_be_n[i]) mem_b[b_raddr[4:0]][i*8 +: 8] = b_bus[i*8 +: 8];

`ifdef SRAM_ASYNC_CTRL_REQ_BUF_EN
    localparam logic READY_C1 = 1'b1;
`else
    localparam logic READY_C1 = 1'b0;
`endif

    initial begin
        logic        acc, prev_we;
        int          k, nresp, stage, we_low, we_rise, oe_first, oe_cnt;
        int          bus_bad, turn_ok, rresp_cyc;
        logic [31:0] rd_got;
        logic [31:0] got [4];
        int          at [4];

        for (int i = 0; i < 32; i++) begin
            mem_a[i] = 32'h1000_0000 + i;
            mem_b[i] = 32'h0;
        end
        a_valid = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_wmask = '0;
        b_valid = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_wmask = '0;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_ready", a_ready, 1);
        chk("rst_ce_n", a_ce_n, 1);
        chk("rst_oe_n", a_oe_n, 1);
        chk("rst_we_n", a_we_n, 1);
        chk("rst_be_n", a_be_n, 4'hF);
        chk("rst_addr", a_raddr, 0);
        chk("rst_resp", a_resp, 0);
        chk("rst_rdata", a_rdata, 0);
        reset_n = 1;
        @(negedge clock);

        // Full write 0xDEADBEEF to 0x10
        a_valid = 1; a_we = 1; a_addr = 20'h10; a_wdata = 32'hDEADBEEF; a_wmask = 4'hF;
        @(negedge clock); a_valid = 0;
        chk("wr1_we_n", a_we_n, 0);
        chk("wr1_ce_n", a_ce_n, 0);
        chk("wr1_oe_n", a_oe_n, 1);
        chk("wr1_be_n", a_be_n, 4'h0);
        chk("wr1_addr", a_raddr, 20'h10);
        chk("wr1_bus", a_bus, 32'hDEADBEEF);
        chk("wr1_ready_busy", a_ready, 0);
        @(negedge clock);
        chk("wr1_resp", a_resp, 1);
        chk("wr1_turn_we_n", a_we_n, 1);
        chk("wr1_turn_bus", a_bus, 32'hDEADBEEF);
        chk("wr1_turn_ready", a_ready, 0);
        chk("wr1_rdata_hold", a_rdata, 0);
        @(negedge clock);
        chk("wr1_ready", a_ready, 1);
        chk("wr1_resp_pulse", a_resp, 0);

        // Read it back
        a_valid = 1; a_we = 0;
        @(negedge clock); a_valid = 0;
        chk("rd1_oe_n", a_oe_n, 0);
        chk("rd1_be_n", a_be_n, 4'h0);
        chk("rd1_resp_early", a_resp, 0);
        @(negedge clock);
        chk("rd1_resp", a_resp, 1);
        chk("rd1_rdata", a_rdata, 32'hDEADBEEF);
        chk("rd1_ready", a_ready, 1);
        chk("rd1_oe_done", a_oe_n, 1);

        // Byte-masked write, byte 1 only
        a_valid = 1; a_we = 1; a_wdata = 32'h0000AA00; a_wmask = 4'h2;
        @(negedge clock); a_valid = 0;
        chk("mw_be_n", a_be_n, 4'hD);
        chk("mw_bus", a_bus, 32'h0000AA00);
        @(negedge clock);
        chk("mw_resp", a_resp, 1);
        chk("mw_rdata_hold", a_rdata, 32'hDEADBEEF);
        @(negedge clock);
        a_valid = 1; a_we = 0;
        @(negedge clock); a_valid = 0;
        @(negedge clock);
        chk("mr_resp", a_resp, 1);
        chk("mr_rdata", a_rdata, 32'hDEADAAEF);

        // Zero mask write still runs a full write and responds
        a_valid = 1; a_we = 1; a_wdata = 32'h12345678; a_wmask = 4'h0;
        @(negedge clock); a_valid = 0;
        chk("zm_we_n", a_we_n, 0);
        chk("zm_be_n", a_be_n, 4'hF);
        @(negedge clock);
        chk("zm_resp", a_resp, 1);
        @(negedge clock);
        a_valid = 1; a_we = 0;
        @(negedge clock); a_valid = 0;
        @(negedge clock);
        chk("zm_rdata", a_rdata, 32'hDEADAAEF);

        // Reset in the middle of a write
        a_valid = 1; a_we = 1; a_addr = 20'h3; a_wdata = 32'h55555555; a_wmask = 4'hF;
        @(negedge clock); a_valid = 0;
        chk("ra_pre_we_n", a_we_n, 0);
        #2 reset_n = 0;
        #1;
        chk("ra_we_n", a_we_n, 1);
        chk("ra_ce_n", a_ce_n, 1);
        chk("ra_be_n", a_be_n, 4'hF);
        chk("ra_addr", a_raddr, 0);
        chk("ra_ready", a_ready, 1);
        @(negedge clock); reset_n = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("ra_no_resp", a_resp, 0);
            chk("ra_ready_after", a_ready, 1);
        end

        // Instance B: write immediately followed by read
        b_valid = 1; b_we = 1; b_addr = 20'h5; b_wdata = 32'hCAFEF00D; b_wmask = 4'hF;
        stage = 0; we_low = 0; we_rise = -1; oe_first = -1; oe_cnt = 0;
        bus_bad = 0; turn_ok = 0; rresp_cyc = -1; rd_got = '0; prev_we = 1;
        for (int c = 0; c < 16; c++) begin
            acc = b_valid && b_ready;
            @(negedge clock);
            if (!b_we_n) we_low++;
            if (b_we_n && !prev_we && we_rise < 0) we_rise = c + 1;
            prev_we = b_we_n;
            if (!b_oe_n) begin
                oe_cnt++;
                if (oe_first < 0) oe_first = c + 1;
                if (b_bus !== 32'hCAFEF00D) bus_bad++;
            end
            if ((c + 1 == 3 || c + 1 == 4) && b_bus === 32'hCAFEF00D && b_we_n && b_oe_n) turn_ok++;
            if (b_resp) begin rresp_cyc = c + 1; rd_got = b_rdata; end
            if (acc) begin
                if (stage == 0) begin stage = 1; b_we = 0; end
                else b_valid = 0;
            end
        end
        chk("b_we_low_cycles", 64'(we_low), 2);
        chk("b_we_rise_cycle", 64'(we_rise), 3);
        chk("b_turn_bus_held", 64'(turn_ok), 2);
        chk("b_oe_first_cycle", 64'(oe_first), 6);
        chk("b_oe_low_cycles", 64'(oe_cnt), 3);
        chk("b_bus_conflict", 64'(bus_bad), 0);
        chk("b_rd_resp_cycle", 64'(rresp_cyc), 9);
        chk("b_rd_data", rd_got, 32'hCAFEF00D);

        // Instance A: four back-to-back reads to 0..3
        a_valid = 1; a_we = 0; a_addr = 20'h0;
        k = 0; nresp = 0;
        for (int i = 0; i < 4; i++) begin got[i] = '0; at[i] = -1; end
        for (int c = 0; c < 20; c++) begin
            acc = a_valid && a_ready;
            if (c == 1) chk("b2b_ready_c1", a_ready, READY_C1);
            @(negedge clock);
            if (a_resp) begin
                if (nresp < 4) begin got[nresp] = a_rdata; at[nresp] = c + 1; end
                nresp++;
            end
            if (acc) begin
                k++;
                if (k < 4) a_addr = 20'(k);
                else a_valid = 0;
            end
        end
        chk("b2b_resp_count", 64'(nresp), 4);
        for (int i = 0; i < 4; i++) begin
            chk("b2b_data", got[i], 64'(32'h1000_0000 + i));
            chk("b2b_cycle", 64'(at[i]), 64'(2 + 2 * i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
